// File: rtl/bits2bytes_stream.sv
// bits2bytes_stream: packs a stream of IN_BITS-wide words LSB-first into
// OUT_BYTES-wide byte beats with valid/ready on both sides. The final word
// of a packet drains the accumulator. The last beat may be zero-padded and
// carries a byte-keep mask.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   in_valid_i/in_ready_o input word handshake
//   in_bits_i             input word, bit 0 earliest in the stream
//   in_last_i             input word is the last of its packet
//   out_valid_o/out_ready_i output beat handshake
//   out_bytes_o           beat data, byte i = stream bits 8i..8i+7
//   out_keep_o            byte i of the beat carries data
//   out_last_o            beat is the last of its packet
module bits2bytes_stream #(
    parameter int unsigned IN_BITS   = 12,
    parameter int unsigned OUT_BYTES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [IN_BITS-1:0]        in_bits_i,
    input  logic                      in_last_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [OUT_BYTES-1:0][7:0] out_bytes_o,
    output logic [OUT_BYTES-1:0]      out_keep_o,
    output logic                      out_last_o
);

    localparam int unsigned OUT_W = 8 * OUT_BYTES;
    localparam int unsigned ACC_W = OUT_W + IN_BITS;
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);

    localparam logic [CNT_W-1:0] OUT_W_C   = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] IN_BITS_C = CNT_W'(IN_BITS);

    generate
        if (IN_BITS < 1 || IN_BITS > OUT_W) begin : g_bad_params
            $error("bits2bytes_stream: IN_BITS must be in 1..8*OUT_BYTES");
        end
    endgenerate

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } mode_t;

    mode_t              mode;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic               last_beat;
    logic               pop;
    logic               push;
    logic [ACC_W-1:0]   acc_pop;
    logic [CNT_W-1:0]   cnt_pop;

    // Beat decode, purely from registered state
    assign last_beat   = (mode == DRAIN) && (cnt <= OUT_W_C);
    assign out_valid_o = (mode == DRAIN) ? (cnt != '0) : (cnt >= OUT_W_C);
    assign out_last_o  = last_beat;
    assign out_bytes_o = acc[OUT_W-1:0];

    // Partial keep only on the final drained beat: ceil(cnt/8) bytes
    always_comb begin
        out_keep_o = '0;
        if (out_valid_o) begin
            if (last_beat) begin
                for (int i = 0; i < int'(OUT_BYTES); i++) begin
                    out_keep_o[i] = (CNT_W'(8 * i) < cnt);
                end
            end else begin
                out_keep_o = '1;
            end
        end
    end

    // Room exists if the current beat is not over-full or is leaving this cycle
    assign in_ready_o = (mode == FILL) && ((cnt <= OUT_W_C) || out_ready_i);

    assign pop  = out_valid_o && out_ready_i;
    assign push = in_valid_i && in_ready_o;

    // Accumulator after any same-cycle pop; a push lands on top of this
    always_comb begin
        acc_pop = acc;
        cnt_pop = cnt;
        if (pop) begin
            acc_pop = acc >> OUT_W;
            cnt_pop = (cnt >= OUT_W_C) ? (cnt - OUT_W_C) : '0;
        end
    end

    // State register: accumulator, fill count and mode
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc  <= '0;
            cnt  <= '0;
            mode <= FILL;
        end else if (pop && last_beat) begin
            acc  <= '0;
            cnt  <= '0;
            mode <= FILL;
        end else begin
            if (push) begin
                acc <= acc_pop | (ACC_W'(in_bits_i) << cnt_pop);
                cnt <= cnt_pop + IN_BITS_C;
                if (in_last_i) begin
                    mode <= DRAIN;
                end
            end else begin
                acc <= acc_pop;
                cnt <= cnt_pop;
            end
        end
    end

endmodule

// File: tb/tb_bits2bytes_stream.sv
// Directed bench for bits2bytes_stream: three instances (8/4, 12/4, 1/1)
// share one clock and reset; each scenario task checks its own results.
module tb_bits2bytes_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // IN_BITS=8, OUT_BYTES=4
    logic            iv8, ir8, il8, ov8, ordy8, ol8;
    logic [7:0]      ib8;
    logic [3:0][7:0] ob8;
    logic [3:0]      ok8;

    // IN_BITS=12, OUT_BYTES=4
    logic            iv12, ir12, il12, ov12, ordy12, ol12;
    logic [11:0]     ib12;
    logic [3:0][7:0] ob12;
    logic [3:0]      ok12;

    // IN_BITS=1, OUT_BYTES=1
    logic            iv1, ir1, il1, ov1, ordy1, ol1;
    logic [0:0]      ib1;
    logic [0:0][7:0] ob1;
    logic [0:0]      ok1;

    bits2bytes_stream #(.IN_BITS(8), .OUT_BYTES(4)) u8 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(iv8), .in_ready_o(ir8), .in_bits_i(ib8), .in_last_i(il8),
        .out_valid_o(ov8), .out_ready_i(ordy8), .out_bytes_o(ob8),
        .out_keep_o(ok8), .out_last_o(ol8)
    );

    bits2bytes_stream #(.IN_BITS(12), .OUT_BYTES(4)) u12 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(iv12), .in_ready_o(ir12), .in_bits_i(ib12), .in_last_i(il12),
        .out_valid_o(ov12), .out_ready_i(ordy12), .out_bytes_o(ob12),
        .out_keep_o(ok12), .out_last_o(ol12)
    );

    bits2bytes_stream #(.IN_BITS(1), .OUT_BYTES(1)) u1 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(iv1), .in_ready_o(ir1), .in_bits_i(ib1), .in_last_i(il1),
        .out_valid_o(ov1), .out_ready_i(ordy1), .out_bytes_o(ob1),
        .out_keep_o(ok1), .out_last_o(ol1)
    );

    // Beat capture; handshake inputs are stable between negedge and posedge
    logic [31:0] q12d[$];
    logic [3:0]  q12k[$];
    logic        q12l[$];
    logic [7:0]  q1d[$];
    logic        q1k[$];
    logic        q1l[$];

    always @(negedge clk) begin
        if (!rst && ov12 && ordy12) begin
            q12d.push_back(ob12);
            q12k.push_back(ok12);
            q12l.push_back(ol12);
        end
        if (!rst && ov1 && ordy1) begin
            q1d.push_back(ob1);
            q1k.push_back(ok1);
            q1l.push_back(ol1);
        end
    end

    task automatic push8(input logic [7:0] w, input logic last);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        iv8 = 1'b1; ib8 = w; il8 = last;
        do begin
            @(negedge clk);
            acc = ir8;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL push8_accept: word %h not accepted within %0d cycles", w, n);
        end
        iv8 = 1'b0; il8 = 1'b0;
    endtask

    task automatic push12(input logic [11:0] w, input logic last);
        logic acc;
        int   n;
        acc  = 1'b0;
        n    = 0;
        iv12 = 1'b1; ib12 = w; il12 = last;
        do begin
            @(negedge clk);
            acc = ir12;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL push12_accept: word %h not accepted within %0d cycles", w, n);
        end
        iv12 = 1'b0; il12 = 1'b0;
    endtask

    task automatic wait_beats12(input int n);
        int c;
        c = 0;
        while (q12d.size() < n && c < 50) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (q12d.size() !== n) begin
            errors++;
            $display("FAIL beats12_count: got %0d beats, expected %0d", q12d.size(), n);
        end
    endtask

    task automatic check_beat12(input string name, input int idx, input logic [31:0] d,
                                input logic [3:0] k, input logic l);
        checks++;
        if (q12d.size() <= idx) begin
            errors++;
            $display("FAIL %s: beat %0d missing", name, idx);
        end else if (q12d[idx] !== d || q12k[idx] !== k || q12l[idx] !== l) begin
            errors++;
            $display("FAIL %s: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                     name, q12d[idx], q12k[idx], q12l[idx], d, k, l);
        end
    endtask

    task automatic clear_queues();
        q12d.delete(); q12k.delete(); q12l.delete();
        q1d.delete();  q1k.delete();  q1l.delete();
    endtask

    // Four bytes, one exact beat, held by backpressure then released
    task automatic run_case1(input string name);
        ordy8 = 1'b0;
        push8(8'h11, 1'b0);
        push8(8'h22, 1'b0);
        push8(8'h33, 1'b0);
        push8(8'h44, 1'b1);
        checks++;
        if (ov8 !== 1'b1 || ol8 !== 1'b1 || ok8 !== 4'b1111) begin
            errors++;
            $display("FAIL %s_ctl: valid=%b last=%b keep=%b, expected 1 1 1111", name, ov8, ol8, ok8);
        end
        checks++;
        if (ob8 !== 32'h44332211) begin
            errors++;
            $display("FAIL %s_data: got %h expected 44332211", name, ob8);
        end
        checks++;
        if (ir8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain_ready: got %b expected 0", name, ir8);
        end
        ordy8 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || ok8 !== 4'b0000 || ol8 !== 1'b0 || ob8 !== 32'h0) begin
            errors++;
            $display("FAIL %s_after: valid=%b ready=%b keep=%b last=%b data=%h, expected 0 1 0000 0 0",
                     name, ov8, ir8, ok8, ol8, ob8);
        end
        ordy8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv8 = 0; il8 = 0; ib8 = '0; ordy8 = 0;
        iv12 = 0; il12 = 0; ib12 = '0; ordy12 = 0;
        iv1 = 0; il1 = 0; ib1 = '0; ordy1 = 0;
        #1;
        checks++;
        if (ov8 !== 1'b0 || ob8 !== 32'h0 || ok8 !== 4'b0 || ol8 !== 1'b0 || ir8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_u8: valid=%b data=%h keep=%b last=%b ready=%b, expected 0 0 0 0 1",
                     ov8, ob8, ok8, ol8, ir8);
        end
        checks++;
        if (ov12 !== 1'b0 || ir12 !== 1'b1 || ov1 !== 1'b0 || ir1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_others: v12=%b r12=%b v1=%b r1=%b, expected 0 1 0 1",
                     ov12, ir12, ov1, ir1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_exact_beat();
        run_case1("exact_beat");
    endtask

    task automatic test_partial_flush();
        clear_queues();
        ordy12 = 1'b1;
        push12(12'hABC, 1'b0);
        push12(12'hDEF, 1'b0);
        push12(12'h123, 1'b1);
        wait_beats12(2);
        check_beat12("partial_beat0", 0, 32'h23DEFABC, 4'b1111, 1'b0);
        check_beat12("partial_beat1", 1, 32'h00000001, 4'b0001, 1'b1);
        checks++;
        if (ov12 !== 1'b0 || ir12 !== 1'b1) begin
            errors++;
            $display("FAIL partial_idle: valid=%b ready=%b, expected 0 1", ov12, ir12);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] w [8];
        w = '{12'h321, 12'h654, 12'h987, 12'hCBA, 12'h210, 12'h543, 12'h876, 12'hBA9};
        clear_queues();
        ordy12 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            iv12 = 1'b1; ib12 = w[i]; il12 = (i == 7);
            @(negedge clk);
            checks++;
            if (ir12 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: word %0d ready=%b expected 1", i, ir12);
            end
            @(posedge clk);
            #1;
        end
        iv12 = 1'b0; il12 = 1'b0;
        wait_beats12(3);
        check_beat12("b2b_beat0", 0, 32'h87654321, 4'b1111, 1'b0);
        check_beat12("b2b_beat1", 1, 32'h3210CBA9, 4'b1111, 1'b0);
        check_beat12("b2b_beat2", 2, 32'hBA987654, 4'b1111, 1'b1);
    endtask

    task automatic test_backpressure();
        clear_queues();
        ordy12 = 1'b0;
        push12(12'hABC, 1'b0);
        push12(12'hDEF, 1'b0);
        push12(12'h123, 1'b0);
        iv12 = 1'b1; ib12 = 12'h456; il12 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ir12 !== 1'b0 || ov12 !== 1'b1) begin
                errors++;
                $display("FAIL bp_handshake: cycle %0d ready=%b valid=%b, expected 0 1", i, ir12, ov12);
            end
            checks++;
            if (ob12 !== 32'h23DEFABC || ok12 !== 4'b1111 || ol12 !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable: cycle %0d data=%h keep=%b last=%b, expected 23defabc 1111 0",
                         i, ob12, ok12, ol12);
            end
            @(posedge clk);
            #1;
        end
        ordy12 = 1'b1;
        push12(12'h456, 1'b0);
        push12(12'h789, 1'b1);
        wait_beats12(2);
        check_beat12("bp_beat0", 0, 32'h23DEFABC, 4'b1111, 1'b0);
        check_beat12("bp_beat1", 1, 32'h07894561, 4'b1111, 1'b1);
    endtask

    task automatic test_single_bit();
        logic b [10];
        int   c;
        b = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        clear_queues();
        ordy1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iv1 = 1'b1; ib1 = b[i]; il1 = (i == 9);
            @(negedge clk);
            checks++;
            if (ir1 !== 1'b1) begin
                errors++;
                $display("FAIL bit_ready: bit %0d ready=%b expected 1", i, ir1);
            end
            @(posedge clk);
            #1;
        end
        iv1 = 1'b0; il1 = 1'b0;
        c = 0;
        while (q1d.size() < 2 && c < 50) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (q1d.size() !== 2) begin
            errors++;
            $display("FAIL bit_count: got %0d beats expected 2", q1d.size());
        end else begin
            checks++;
            if (q1d[0] !== 8'h4D || q1k[0] !== 1'b1 || q1l[0] !== 1'b0) begin
                errors++;
                $display("FAIL bit_beat0: got %h keep=%b last=%b, expected 4d 1 0", q1d[0], q1k[0], q1l[0]);
            end
            checks++;
            if (q1d[1] !== 8'h03 || q1k[1] !== 1'b1 || q1l[1] !== 1'b1) begin
                errors++;
                $display("FAIL bit_beat1: got %h keep=%b last=%b, expected 03 1 1", q1d[1], q1k[1], q1l[1]);
            end
        end
    endtask

    task automatic test_midpacket_reset();
        ordy8 = 1'b0;
        push8(8'h11, 1'b0);
        push8(8'h22, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ov8 !== 1'b0 || ob8 !== 32'h0 || ok8 !== 4'b0 || ol8 !== 1'b0 || ir8 !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h keep=%b last=%b ready=%b, expected 0 0 0 0 1",
                     ov8, ob8, ok8, ol8, ir8);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_case1("post_reset");
    endtask

    initial begin
        test_reset();
        test_exact_beat();
        test_partial_flush();
        test_back_to_back();
        test_backpressure();
        test_single_bit();
        test_midpacket_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
